// File: rtl/pipe_hazard_ctrl_pkg.sv
// Types and constants shared between the hazard unit and the core pipeline.
package pipe_ctrl_pkg;

  localparam int NREG  = 32;
  localparam int REG_W = $clog2(NREG);

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             is_load;
  } stage_shadow_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side request and pipeline-control response bundle of the hazard unit.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int RW    = 5,
  parameter int CNT_W = 16
);

  logic           id_valid;
  logic [RW-1:0]  id_rs1;
  logic [RW-1:0]  id_rs2;
  logic           id_rs1_used;
  logic           id_rs2_used;
  logic [RW-1:0]  id_rd;
  logic           id_regwrite;
  logic           id_is_load;
  logic           ex_redirect;

  logic           stall_if;
  logic           stall_id;
  logic           bubble_ex;
  logic           flush_ifid;
  fwd_sel_e       fwd_a;
  fwd_sel_e       fwd_b;
  logic           issue;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_is_load, ex_redirect,
    input  stall_if, stall_id, bubble_ex, flush_ifid, fwd_a, fwd_b,
           issue, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_is_load, ex_redirect,
    output stall_if, stall_id, bubble_ex, flush_ifid, fwd_a, fwd_b,
           issue, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_dep_cmp.sv
// Writer-match comparator: true when a stage entry writes the given source register.
module pipe_dep_cmp #(
  parameter int RW = 5
) (
  input  logic          i_valid,
  input  logic          i_regwrite,
  input  logic [RW-1:0] i_rd,
  input  logic [RW-1:0] i_src,
  output logic          o_match
);

  // x0 is hardwired zero, so a write to it never creates a dependence.
  assign o_match = i_valid && i_regwrite && (i_rd == i_src) && (i_src != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, bubble/flush control and EX operand forwarding for the 5-stage core.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NREG   = pipe_ctrl_pkg::NREG,
  parameter int RW     = $clog2(NREG),
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  pipe_hazard_ctrl_if.slave bus
);

  stage_shadow_t r_ex, r_mem, r_wb;
  logic [RW-1:0] r_ex_src  [2];
  logic          r_ex_used [2];
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic [RW-1:0] w_id_src  [2];
  logic          w_id_used [2];
  logic [1:0]    w_id_hit_ex, w_id_hit_mem, w_ex_hit_mem, w_ex_hit_wb;
  logic [1:0]    w_haz_src, w_ld_fwd_viol;
  fwd_sel_e      w_fwd [2];
  logic          w_stall, w_issue;
  logic          w_unused_ok;

  assign w_id_src[0]  = bus.id_rs1;
  assign w_id_src[1]  = bus.id_rs2;
  assign w_id_used[0] = bus.id_valid && bus.id_rs1_used;
  assign w_id_used[1] = bus.id_valid && bus.id_rs2_used;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      pipe_dep_cmp #(.RW(RW)) u_id_ex (
        .i_valid(r_ex.valid), .i_regwrite(r_ex.regwrite), .i_rd(r_ex.rd),
        .i_src(w_id_src[gi]), .o_match(w_id_hit_ex[gi])
      );
      pipe_dep_cmp #(.RW(RW)) u_id_mem (
        .i_valid(r_mem.valid), .i_regwrite(r_mem.regwrite), .i_rd(r_mem.rd),
        .i_src(w_id_src[gi]), .o_match(w_id_hit_mem[gi])
      );
      pipe_dep_cmp #(.RW(RW)) u_ex_mem (
        .i_valid(r_mem.valid), .i_regwrite(r_mem.regwrite), .i_rd(r_mem.rd),
        .i_src(r_ex_src[gi]), .o_match(w_ex_hit_mem[gi])
      );
      pipe_dep_cmp #(.RW(RW)) u_ex_wb (
        .i_valid(r_wb.valid), .i_regwrite(r_wb.regwrite), .i_rd(r_wb.rd),
        .i_src(r_ex_src[gi]), .o_match(w_ex_hit_wb[gi])
      );

      if (FWD_EN != 0) begin : g_fwd
        assign w_haz_src[gi] = w_id_used[gi] && w_id_hit_ex[gi] && r_ex.is_load;
        // A load result is not ready in MEM; the load-use stall keeps consumers out.
        assign w_fwd[gi] = (r_ex_used[gi] && w_ex_hit_mem[gi] && !r_mem.is_load) ? FWD_EXMEM :
                           (r_ex_used[gi] && w_ex_hit_wb[gi])                     ? FWD_MEMWB :
                                                                                    FWD_REG;
      end else begin : g_nofwd
        assign w_haz_src[gi] = w_id_used[gi] && (w_id_hit_ex[gi] || w_id_hit_mem[gi]);
        assign w_fwd[gi]     = FWD_REG;
      end

      assign w_ld_fwd_viol[gi] = r_ex_used[gi] && w_ex_hit_mem[gi] && r_mem.is_load;
    end
  endgenerate

  assign w_stall = (|w_haz_src) && !bus.ex_redirect;
  assign w_issue = bus.id_valid && !w_stall && !bus.ex_redirect;

  assign bus.stall_if   = w_stall;
  assign bus.stall_id   = w_stall;
  assign bus.bubble_ex  = w_stall || bus.ex_redirect;
  assign bus.flush_ifid = bus.ex_redirect;
  assign bus.issue      = w_issue;
  assign bus.fwd_a      = w_fwd[0];
  assign bus.fwd_b      = w_fwd[1];
  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.flush_cnt  = r_flush_cnt;

  // WB load flag is tracked for the core's benefit but not needed for any decision here.
  assign w_unused_ok = r_wb.is_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex         <= '0;
      r_mem        <= '0;
      r_wb         <= '0;
      r_ex_src[0]  <= '0;
      r_ex_src[1]  <= '0;
      r_ex_used[0] <= 1'b0;
      r_ex_used[1] <= 1'b0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_issue) begin
        r_ex         <= '{valid: 1'b1, rd: bus.id_rd, regwrite: bus.id_regwrite,
                          is_load: bus.id_is_load};
        r_ex_src[0]  <= bus.id_rs1;
        r_ex_src[1]  <= bus.id_rs2;
        r_ex_used[0] <= bus.id_rs1_used;
        r_ex_used[1] <= bus.id_rs2_used;
      end else begin
        r_ex         <= '0;
        r_ex_src[0]  <= '0;
        r_ex_src[1]  <= '0;
        r_ex_used[0] <= 1'b0;
        r_ex_used[1] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (bus.ex_redirect && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n)
      assert (w_ld_fwd_viol == 2'b00);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: one full-forwarding unit and one stall-only unit with 2-bit counters.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   use_f = 1'b1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.RW(5), .CNT_W(16)) f_if ();
  pipe_hazard_ctrl_if #(.RW(5), .CNT_W(2))  s_if ();

  pipe_hazard_ctrl #(.NREG(32), .RW(5), .FWD_EN(1), .CNT_W(16)) u_fwd (
    .clk(clk), .reset_n(reset_n), .bus(f_if.slave)
  );
  pipe_hazard_ctrl #(.NREG(32), .RW(5), .FWD_EN(0), .CNT_W(2)) u_stl (
    .clk(clk), .reset_n(reset_n), .bus(s_if.slave)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Present one ID instruction to the selected unit; the other sees an idle decode.
  task automatic drv(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit rw, input bit ld, input bit rdr);
    f_if.id_rs1 = 5'(rs1);  s_if.id_rs1 = 5'(rs1);
    f_if.id_rs2 = 5'(rs2);  s_if.id_rs2 = 5'(rs2);
    f_if.id_rs1_used = u1;  s_if.id_rs1_used = u1;
    f_if.id_rs2_used = u2;  s_if.id_rs2_used = u2;
    f_if.id_rd = 5'(rd);    s_if.id_rd = 5'(rd);
    f_if.id_regwrite = rw;  s_if.id_regwrite = rw;
    f_if.id_is_load = ld;   s_if.id_is_load = ld;
    f_if.id_valid    = use_f ? v : 1'b0;
    s_if.id_valid    = use_f ? 1'b0 : v;
    f_if.ex_redirect = use_f ? rdr : 1'b0;
    s_if.ex_redirect = use_f ? 1'b0 : rdr;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst stall_if", int'(f_if.stall_if), 0);
    chk("rst bubble", int'(f_if.bubble_ex), 0);
    chk("rst flush", int'(f_if.flush_ifid), 0);
    chk("rst fwd_a", int'(f_if.fwd_a), 0);
    chk("rst issue", int'(f_if.issue), 1);
    chk("rst stall_cnt", int'(f_if.stall_cnt), 0);
    step(); reset_n = 1'b1;

    // Load-use: lw x5 ; add x6,x5,x1
    drv(1, 1, 1, 0, 0, 5, 1, 1, 0); #1;
    chk("lw issue", int'(f_if.issue), 1);
    step(); drv(1, 5, 1, 1, 1, 6, 1, 0, 0); #1;
    chk("lu stall_if", int'(f_if.stall_if), 1);
    chk("lu stall_id", int'(f_if.stall_id), 1);
    chk("lu bubble", int'(f_if.bubble_ex), 1);
    chk("lu issue", int'(f_if.issue), 0);
    step(); #1;
    chk("lu stall_cnt", int'(f_if.stall_cnt), 1);
    chk("lu 2nd stall", int'(f_if.stall_if), 0);
    chk("lu 2nd issue", int'(f_if.issue), 1);

    // addi x3,x0 ; consumer of the load sits in EX with the load in WB
    step(); drv(1, 0, 1, 0, 0, 3, 1, 0, 0); #1;
    chk("lu fwd_a", int'(f_if.fwd_a), 2);
    chk("lu fwd_b", int'(f_if.fwd_b), 0);
    step(); drv(1, 3, 1, 3, 1, 4, 1, 0, 0); #1;
    chk("alu nostall", int'(f_if.stall_if), 0);
    chk("alu issue", int'(f_if.issue), 1);
    chk("addi fwd_a x0", int'(f_if.fwd_a), 0);
    step(); drv(1, 0, 1, 0, 0, 7, 1, 0, 0); #1;
    chk("b2b fwd_a", int'(f_if.fwd_a), 1);
    chk("b2b fwd_b", int'(f_if.fwd_b), 1);

    // Second writer of x7, then add x10,x7,x0; probe the consumer while in EX
    step(); drv(1, 0, 1, 0, 0, 7, 1, 0, 0); #1;
    step(); drv(1, 7, 1, 0, 1, 10, 1, 0, 0); #1;
    step(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("dbl fwd_a", int'(f_if.fwd_a), 1);
    chk("dbl fwd_b", int'(f_if.fwd_b), 0);

    // Writer of x0, then reader of x0
    step(); drv(1, 1, 1, 0, 0, 0, 1, 0, 0); #1;
    step(); drv(1, 0, 1, 0, 1, 11, 1, 0, 0); #1;
    chk("x0 stall", int'(f_if.stall_if), 0);
    step(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("x0 fwd_a", int'(f_if.fwd_a), 0);
    chk("x0 fwd_b", int'(f_if.fwd_b), 0);

    // Redirect coincident with a load-use hazard
    step(); drv(1, 1, 1, 0, 0, 12, 1, 1, 0); #1;
    step(); drv(1, 12, 1, 0, 1, 13, 1, 0, 1); #1;
    chk("rd flush", int'(f_if.flush_ifid), 1);
    chk("rd stall_if", int'(f_if.stall_if), 0);
    chk("rd issue", int'(f_if.issue), 0);
    chk("rd bubble", int'(f_if.bubble_ex), 1);
    step(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("rd flush_cnt", int'(f_if.flush_cnt), 1);
    chk("rd stall_cnt", int'(f_if.stall_cnt), 1);
    chk("rd flush off", int'(f_if.flush_ifid), 0);

    // Reset in the middle of a load-use stall
    step(); drv(1, 1, 1, 0, 0, 14, 1, 1, 0); #1;
    step(); drv(1, 14, 1, 0, 0, 15, 1, 0, 0); #1;
    chk("mid stall", int'(f_if.stall_if), 1);
    reset_n = 1'b0; #1;
    chk("mid rst stall", int'(f_if.stall_if), 0);
    chk("mid rst bubble", int'(f_if.bubble_ex), 0);
    chk("mid rst issue", int'(f_if.issue), 1);
    chk("mid rst stall_cnt", int'(f_if.stall_cnt), 0);
    chk("mid rst flush_cnt", int'(f_if.flush_cnt), 0);
    step(); reset_n = 1'b1; #1;
    chk("post rst stall", int'(f_if.stall_if), 0);
    chk("post rst issue", int'(f_if.issue), 1);

    // Stall-only unit: addi x2 ; add x8,x2,x0 costs two stalls
    use_f = 1'b0;
    step(); drv(1, 0, 1, 0, 0, 2, 1, 0, 0); #1;
    chk("s issue", int'(s_if.issue), 1);
    step(); drv(1, 2, 1, 0, 1, 8, 1, 0, 0); #1;
    chk("s stall1", int'(s_if.stall_if), 1);
    chk("s fwd_a1", int'(s_if.fwd_a), 0);
    step(); #1;
    chk("s stall2", int'(s_if.stall_if), 1);
    chk("s bubble2", int'(s_if.bubble_ex), 1);
    step(); #1;
    chk("s stall3", int'(s_if.stall_if), 0);
    chk("s issue3", int'(s_if.issue), 1);
    chk("s stall_cnt", int'(s_if.stall_cnt), 2);
    step(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("s fwd_a", int'(s_if.fwd_a), 0);
    chk("s fwd_b", int'(s_if.fwd_b), 0);

    // Stall-only x0 writer then reader
    step(); drv(1, 1, 1, 0, 0, 0, 1, 0, 0); #1;
    step(); drv(1, 0, 1, 0, 1, 16, 1, 0, 0); #1;
    chk("s x0 stall", int'(s_if.stall_if), 0);

    // Two more stalls saturate the 2-bit counter at 3
    step(); drv(1, 1, 1, 0, 0, 20, 1, 1, 0); #1;
    step(); drv(1, 20, 1, 0, 0, 21, 1, 0, 0); #1;
    chk("s sat stall", int'(s_if.stall_if), 1);
    step(); #1;
    chk("s sat cnt3", int'(s_if.stall_cnt), 3);
    step(); #1;
    chk("s sat hold", int'(s_if.stall_cnt), 3);
    chk("s sat issue", int'(s_if.issue), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and pipeline-control unit for the 5-stage core. It tracks the destination and source registers of the instructions in EX, MEM and WB, and generates the following:
- stall controls for IF/ID;
- bubble insertion into ID/EX;
- IF/ID flush on an EX-resolved redirect;
- forwarding selects for the EX operand muxes.

A build-time mode selects a full-forwarding or a stall-only (no bypass) pipeline. Saturating stall and flush event counters are included.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- RW, $clog2(NREG), register index width.
- FWD_EN, 1, 1 = bypass network active; 0 = resolve all RAW hazards by stalling.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- id_valid  in  1  decode holds a valid instruction.
- id_rs1, id_rs2  in  RW  source register indices of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  the corresponding source is actually read.
- id_rd  in  RW  destination register of the instruction in ID.
- id_regwrite  in  1  the instruction in ID writes rd.
- id_is_load  in  1  the instruction in ID is a load.
- ex_redirect  in  1  a taken branch or jump is resolved in EX this cycle.
- stall_if  out  1  hold the PC.
- stall_id  out  1  hold IF/ID.
- bubble_ex  out  1  load a NOP (all control fields zero) into ID/EX.
- flush_ifid  out  1  invalidate IF/ID at the next edge.
- fwd_a, fwd_b  out  2  EX operand source: 00 = ID/EX register value, 01 = EX/MEM alu_result, 10 = MEM/WB writeback data.
- issue  out  1  the instruction in ID advances into EX at this edge.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
Shadow state is held per stage:
- EX: valid, rd, regwrite, is_load, rs1, rs2, rs1_used, rs2_used.
- MEM: valid, rd, regwrite, is_load.
- WB: valid, rd, regwrite, is_load.

Stage advance, every edge:
- WB <= MEM; MEM <= EX.
- EX <= ID fields when issue = 1; otherwise EX <= bubble (valid = 0).

A stage entry is a writer of register r only when valid && regwrite && rd == r && r != 0.

Hazard detection, combinational on the ID instruction (id_valid = 1, source used):
- FWD_EN = 1: hazard when EX holds a load that writes a used source.
- FWD_EN = 0: hazard when EX or MEM holds a writer of a used source.
- WB never causes a hazard: the register file is write-before-read.

Output rules:
- stall = hazard && !ex_redirect.
- stall_if = stall_id = stall.
- bubble_ex = stall || ex_redirect.
- flush_ifid = ex_redirect.
- issue = id_valid && !stall && !ex_redirect.
- ex_redirect has priority over stall. The instruction in ID is on the wrong path and is killed, never issued.

Forwarding, combinational on the EX shadow:
- fwd_a = 01 when MEM is a writer of EX.rs1 and EX.rs1_used; else 10 when WB is a writer of EX.rs1 and EX.rs1_used; else 00. fwd_b follows the same rule on rs2.
- MEM has priority over WB, so the youngest value wins.
- A load in MEM is never a forwarding source. The load-use stall guarantees no consumer reaches EX in that case. An assertion must flag the case if it occurs.
- FWD_EN = 0: fwd_a and fwd_b are constant 00.

Counters:
- stall_cnt increments by 1 on each cycle with stall = 1.
- flush_cnt increments by 1 on each cycle with ex_redirect = 1.
- Both hold at 2^CNT_W - 1.

## Timing
- Reset (reset_n low, asynchronous): all shadow valid bits 0 and both counters 0. With no valid stage, outputs are stall_if = stall_id = bubble_ex = flush_ifid = 0 and fwd_a = fwd_b = 00. issue follows id_valid.
- All control outputs are combinational from current inputs and registered shadow state, with zero latency.
- Load-use with FWD_EN = 1 costs exactly 1 stall cycle. The consumer then enters EX with the load in WB and fwd = 10.
- With FWD_EN = 0, a back-to-back dependence costs 2 stall cycles: producer in EX, then producer in MEM.
- A redirect costs 2 bubbles: the killed ID instruction and the EX bubble. The instruction fetched at the target is not affected.
- Reset asserted mid-stall clears all shadow state, so no stale hazard remains after release.

## Structure
- The package pipe_ctrl_pkg holds the following, shared with riscv_core:
  - the fwd_sel_e enum (FWD_REG, FWD_EXMEM, FWD_MEMWB);
  - the stage_shadow_t struct;
  - NREG.
- One sub-module, pipe_dep_cmp: parametrised (RW) writer-match comparator. It takes stage valid, regwrite, rd and a source index, and returns the match. It is instantiated per stage and per source.

## Test plan
- Load-use, FWD_EN = 1: load x5 then add x6,x5,x1 -> one stall cycle (stall_if = 1, bubble_ex = 1, stall_cnt = 1); the add then issues with fwd_a = 10.
- ALU back-to-back, FWD_EN = 1: addi x3 then sub x4,x3,x3 -> no stall; fwd_a = fwd_b = 01. A third instruction reading x3 sees fwd = 10.
- Double writer: two writers of x7 in MEM and WB -> fwd_a = 01, because MEM has priority.
- Writes to x0: a writer of x0 followed by a reader of x0 -> no stall and fwd = 00, in both FWD_EN modes.
- FWD_EN = 0 dependence: addi x2 then add x8,x2,x0 -> two stall cycles; stall_cnt = 2; fwd stays 00.
- Redirect during stall: ex_redirect = 1 coincident with a load-use hazard -> flush_ifid = 1, stall_if = 0, issue = 0, flush_cnt = 1. Separately, assert reset_n low mid-stall -> all outputs return to their reset values immediately.
